// File: rtl/drng_pkg.sv
// Shared types and default constants for the 129-bit LFSR DRNG/post-processor.
package drng_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SEED   = 3'd1,
    ST_WARMUP = 3'd2,
    ST_CHECK  = 3'd3,
    ST_OUT    = 3'd4
  } drng_state_e;

  localparam logic [1:0] MODE_OFF  = 2'd0;
  localparam logic [1:0] MODE_DRNG = 2'd1;
  localparam logic [1:0] MODE_MIX  = 2'd2;

  localparam int DEF_LFSR_W = 129;
  localparam logic [128:0] DEF_TAPS = (129'd1 << 8'd128) | (129'd1 << 8'd114) |
                                      (129'd1 << 8'd110) | (129'd1 << 8'd100) |
                                      (129'd1 << 8'd43)  | (129'd1 << 8'd41);
  localparam logic [128:0] DEF_SEED = 129'h1_A39A8864_5DF3BECE_074EC5D3_BAF39D18;

  function automatic logic mode_is_on(input logic [1:0] m);
    return (m == MODE_DRNG) || (m == MODE_MIX);
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci LFSR register: seed load, free-running or noise-mixed step,
// and all-zero lock-up recovery (recovery beats load and step).
module lfsr_core
  import drng_pkg::*;
#(
  parameter int                LFSR_W       = DEF_LFSR_W,
  parameter logic [LFSR_W-1:0] TAPS         = DEF_TAPS,
  parameter logic [LFSR_W-1:0] SEED_DEFAULT = DEF_SEED
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  input  logic              step,
  input  logic              mix,
  input  logic              noise_bit,
  output logic [LFSR_W-1:0] lfsr_r,
  output logic              zero_s
);

  logic new_bit_s;

  // Feedback bit and all-zero detect.
  always_comb begin
    new_bit_s = (^(lfsr_r & TAPS)) ^ (mix & noise_bit);
    zero_s    = (lfsr_r == {LFSR_W{1'b0}});
  end

  // LFSR state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_r <= SEED_DEFAULT;
    end else if (zero_s) begin
      lfsr_r <= SEED_DEFAULT;
    end else if (load) begin
      lfsr_r <= load_val;
    end else if (step) begin
      lfsr_r <= {lfsr_r[LFSR_W-2:0], new_bit_s};
    end
  end

endmodule

// File: rtl/lfsr_drng_gen.sv
// LFSR DRNG/post-processor: seeding handshake, warm-up, repetition check and
// valid/ready word output between the entropy buffer and the RNG FIFO.
module lfsr_drng_gen
  import drng_pkg::*;
#(
  parameter int                LFSR_W       = DEF_LFSR_W,
  parameter int                OUT_W        = 128,
  parameter int                SEED_W       = 256,
  parameter logic [LFSR_W-1:0] TAPS         = DEF_TAPS,
  parameter logic [LFSR_W-1:0] SEED_DEFAULT = DEF_SEED,
  parameter logic [7:0]        WARMUP       = 8'd0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic [15:0]       reseed_limit,
  output logic              seed_req,
  input  logic              seed_vld,
  input  logic [SEED_W-1:0] seed_data,
  input  logic              noise_bit,
  input  logic              noise_vld,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic              rep_err,
  output logic              lockup
);

  localparam logic [7:0]       FIRST_TGT = 8'(int'(WARMUP) + OUT_W);
  localparam logic [7:0]       REP_TGT   = 8'(OUT_W);
  localparam logic [OUT_W-1:0] DEF_WORD  = SEED_DEFAULT[OUT_W-1:0];

  if ((int'(WARMUP) + OUT_W) > 255) begin : g_bad_warmup
    $error("lfsr_drng_gen: WARMUP+OUT_W must fit the 8-bit shift counter");
  end
  if (LFSR_W < OUT_W + 1) begin : g_bad_width
    $error("lfsr_drng_gen: LFSR_W must exceed OUT_W");
  end

  drng_state_e       state_r;
  logic [1:0]        mode_r;
  logic [15:0]       word_cnt_r;
  logic [7:0]        shift_cnt_r;
  logic [7:0]        shift_tgt_r;
  logic [OUT_W-1:0]  prev_r;
  logic              prev_vld_r;
  logic [LFSR_W-1:0] lfsr_s;
  logic              zero_s;
  logic              mode_on_s;
  logic              mode_sw_s;
  logic              run_s;
  logic              load_s;
  logic              step_s;
  logic              mix_s;
  logic [OUT_W-1:0]  word_s;
  logic              unused_lfsr_s;
  logic              unused_seed_s;

  assign unused_lfsr_s = ^lfsr_s[LFSR_W-1:OUT_W];
  if (SEED_W > LFSR_W) begin : g_seed_tail
    assign unused_seed_s = ^seed_data[SEED_W-LFSR_W-1:0];
  end else begin : g_seed_full
    assign unused_seed_s = 1'b0;
  end

  // Mode-change decode and LFSR load/step qualification.
  always_comb begin
    mode_on_s = mode_is_on(mode);
    mode_sw_s = mode_on_s && mode_is_on(mode_r) && (mode != mode_r);
    run_s     = mode_on_s && !mode_sw_s && !zero_s;
    load_s    = run_s && (state_r == ST_SEED) && seed_req && seed_vld;
    step_s    = run_s && (state_r == ST_WARMUP) && ((mode == MODE_DRNG) || noise_vld);
    mix_s     = (mode == MODE_MIX);
    word_s    = lfsr_s[OUT_W-1:0];
  end

  lfsr_core #(
    .LFSR_W      (LFSR_W),
    .TAPS        (TAPS),
    .SEED_DEFAULT(SEED_DEFAULT)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (load_s),
    .load_val (seed_data[SEED_W-1 -: LFSR_W]),
    .step     (step_s),
    .mix      (mix_s),
    .noise_bit(noise_bit),
    .lfsr_r   (lfsr_s),
    .zero_s   (zero_s)
  );

  // Control FSM with counters, repetition check and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      mode_r      <= MODE_OFF;
      word_cnt_r  <= 16'd0;
      shift_cnt_r <= 8'd0;
      shift_tgt_r <= FIRST_TGT;
      prev_r      <= {OUT_W{1'b0}};
      prev_vld_r  <= 1'b0;
      seed_req    <= 1'b0;
      out_vld     <= 1'b0;
      out_data    <= DEF_WORD;
      rep_err     <= 1'b0;
      lockup      <= 1'b0;
    end else begin
      mode_r  <= mode;
      lockup  <= zero_s;
      rep_err <= 1'b0;
      if (!mode_on_s) begin
        state_r     <= ST_IDLE;
        seed_req    <= 1'b0;
        out_vld     <= 1'b0;
        word_cnt_r  <= 16'd0;
        shift_cnt_r <= 8'd0;
        prev_vld_r  <= 1'b0;
      end else if (mode_sw_s) begin
        state_r     <= ST_SEED;
        seed_req    <= 1'b1;
        out_vld     <= 1'b0;
        shift_cnt_r <= 8'd0;
      end else if (!zero_s) begin
        // A lock-up reload cycle freezes all progress below.
        case (state_r)
          ST_IDLE: begin
            state_r  <= ST_SEED;
            seed_req <= 1'b1;
          end
          ST_SEED: begin
            if (load_s) begin
              seed_req    <= 1'b0;
              word_cnt_r  <= 16'd0;
              shift_cnt_r <= 8'd0;
              shift_tgt_r <= FIRST_TGT;
              state_r     <= ST_WARMUP;
            end
          end
          ST_WARMUP: begin
            if (step_s) begin
              if (shift_cnt_r + 8'd1 == shift_tgt_r) begin
                shift_cnt_r <= 8'd0;
                state_r     <= ST_CHECK;
              end else begin
                shift_cnt_r <= shift_cnt_r + 8'd1;
              end
            end
          end
          ST_CHECK: begin
            if (prev_vld_r && (word_s == prev_r)) begin
              rep_err     <= 1'b1;
              shift_cnt_r <= 8'd0;
              shift_tgt_r <= REP_TGT;
              state_r     <= ST_WARMUP;
            end else begin
              out_data <= word_s;
              out_vld  <= 1'b1;
              state_r  <= ST_OUT;
            end
          end
          ST_OUT: begin
            if (out_rdy) begin
              prev_r      <= out_data;
              prev_vld_r  <= 1'b1;
              out_vld     <= 1'b0;
              shift_cnt_r <= 8'd0;
              shift_tgt_r <= REP_TGT;
              if (word_cnt_r != 16'hFFFF) begin
                word_cnt_r <= word_cnt_r + 16'd1;
              end
              if ((reseed_limit != 16'd0) && (word_cnt_r + 16'd1 == reseed_limit)) begin
                state_r  <= ST_SEED;
                seed_req <= 1'b1;
              end else begin
                state_r <= ST_WARMUP;
              end
            end
          end
          default: begin
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lfsr_drng_gen.sv
// Self-checking bench for lfsr_drng_gen: random seeds/noise against a
// step-by-step LFSR reference, with cycle-exact handshake timing checks.
module tb_lfsr_drng_gen;

  localparam int LW = 129;
  localparam int OW = 128;
  localparam int SW = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    mode = 2'd0;
  logic [15:0]   reseed_limit = 16'd0;
  logic          seed_vld = 1'b0;
  logic [SW-1:0] seed_data = '0;
  logic          noise_bit = 1'b0;
  logic          noise_vld = 1'b0;
  logic          out_rdy = 1'b0;
  logic          seed_req;
  logic [OW-1:0] out_data;
  logic          out_vld;
  logic          rep_err;
  logic          lockup;

  int checks = 0;
  int errors = 0;

  logic [LW-1:0] taps;
  logic [LW-1:0] def_seed;

  lfsr_drng_gen dut (
    .clk(clk), .rst(rst), .mode(mode), .reseed_limit(reseed_limit),
    .seed_req(seed_req), .seed_vld(seed_vld), .seed_data(seed_data),
    .noise_bit(noise_bit), .noise_vld(noise_vld),
    .out_data(out_data), .out_vld(out_vld), .out_rdy(out_rdy),
    .rep_err(rep_err), .lockup(lockup)
  );

  always #5 clk = ~clk;

  function automatic logic [LW-1:0] adv(input logic [LW-1:0] s, input logic [LW-1:0] t, input int n);
    for (int i = 0; i < n; i++) s = {s[LW-2:0], ^(s & t)};
    return s;
  endfunction

  function automatic logic [SW-1:0] rnd_seed();
    logic [SW-1:0] r;
    for (int i = 0; i < SW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_vld(input int budget, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!out_vld && n < budget);
  endtask

  initial begin
    int tl[6] = '{128, 114, 110, 100, 43, 41};
    logic [SW-1:0] s;
    logic [SW-1:0] s5;
    logic [LW-1:0] m;
    logic [LW-1:0] e;
    logic [OW-1:0] w1;
    logic [OW-1:0] held;
    int n, steps, reps, rep_at, seen;

    taps = '0;
    foreach (tl[i]) taps[tl[i]] = 1'b1;
    def_seed = 129'h1_A39A8864_5DF3BECE_074EC5D3_BAF39D18;

    // Reset values
    tick(); tick();
    chk("rst_out_vld", 256'(out_vld), 256'(0));
    chk("rst_seed_req", 256'(seed_req), 256'(0));
    chk("rst_rep_err", 256'(rep_err), 256'(0));
    chk("rst_lockup", 256'(lockup), 256'(0));
    chk("rst_out_data", 256'(out_data), 256'(def_seed[OW-1:0]));
    rst = 1'b0;

    // DRNG: seed request timing, first-word latency, golden value
    mode = 2'd1;
    tick();
    chk("drng_seed_req_rise", 256'(seed_req), 256'(1));
    repeat (3) tick();
    chk("drng_seed_req_hold", 256'(seed_req), 256'(1));
    s = rnd_seed();
    s[SW-1 -: LW] = {1'b1, {127{1'b0}}, 1'b1};
    seed_vld = 1'b1; seed_data = s;
    tick();
    seed_vld = 1'b0; seed_data = rnd_seed();
    chk("drng_seed_req_drop", 256'(seed_req), 256'(0));
    wait_vld(1000, n);
    chk("drng_first_latency", 256'(n), 256'(129));
    e = adv(s[SW-1 -: LW], taps, 128);
    chk("drng_word1", 256'(out_data), 256'(e[OW-1:0]));
    held = out_data;
    repeat (5) tick();
    chk("drng_hold_vld", 256'(out_vld), 256'(1));
    chk("drng_hold_data", 256'(out_data), 256'(held));
    out_rdy = 1'b1;
    tick();
    out_rdy = 1'b0;
    chk("drng_vld_drop", 256'(out_vld), 256'(0));
    wait_vld(1000, n);
    chk("drng_second_latency", 256'(n), 256'(129));
    e = adv(s[SW-1 -: LW], taps, 256);
    chk("drng_word2", 256'(out_data), 256'(e[OW-1:0]));

    // DRNG->MIX switch drops the pending word and reseeds; then mode off
    mode = 2'd2;
    tick();
    chk("switch_vld", 256'(out_vld), 256'(0));
    chk("switch_seed_req", 256'(seed_req), 256'(1));
    mode = 2'd0;
    tick();
    chk("off_seed_req", 256'(seed_req), 256'(0));

    // MIX: noise_vld every 4th cycle, random noise bits
    mode = 2'd2;
    tick();
    s = rnd_seed();
    seed_vld = 1'b1; seed_data = s;
    tick();
    seed_vld = 1'b0;
    m = s[SW-1 -: LW];
    steps = 0; n = 0;
    for (int k = 0; k < 2000; k++) begin
      noise_vld = (k % 4 == 3);
      noise_bit = (k < 40) ? 1'b1 : 1'($urandom);
      if (noise_vld && steps < 128) begin
        m = {m[LW-2:0], (^(m & taps)) ^ noise_bit};
        steps++;
      end
      tick();
      n++;
      if (out_vld) break;
    end
    noise_vld = 1'b0;
    chk("mix_latency", 256'(n), 256'(513));
    chk("mix_word", 256'(out_data), 256'(m[OW-1:0]));
    mode = 2'd0;
    tick();

    // Reseed after 3 words; no output until the next seed; count restarts
    reseed_limit = 16'd3; out_rdy = 1'b1; mode = 2'd1;
    tick();
    for (int r = 0; r < 2; r++) begin
      s = rnd_seed();
      seed_vld = 1'b1; seed_data = s;
      tick();
      seed_vld = 1'b0;
      for (int wi = 1; wi <= 3; wi++) begin
        wait_vld(1000, n);
        chk("limit_latency", 256'(n), 256'((wi == 1) ? 129 : 130));
        e = adv(s[SW-1 -: LW], taps, 128 * wi);
        chk("limit_word", 256'(out_data), 256'(e[OW-1:0]));
      end
      tick();
      chk("limit_seed_req", 256'(seed_req), 256'(1));
      if (r == 0) begin
        seen = 0;
        repeat (300) begin
          tick();
          if (out_vld) seen++;
        end
        chk("limit_no_vld", 256'(seen), 256'(0));
        chk("limit_req_held", 256'(seed_req), 256'(1));
      end
    end

    // Repetition: same seed twice with reseed_limit=1
    reseed_limit = 16'd1;
    s5 = rnd_seed();
    seed_vld = 1'b1; seed_data = s5;
    tick();
    seed_vld = 1'b0;
    wait_vld(1000, n);
    e = adv(s5[SW-1 -: LW], taps, 128);
    chk("rep_word1", 256'(out_data), 256'(e[OW-1:0]));
    w1 = out_data;
    tick();
    chk("rep_reseed_req", 256'(seed_req), 256'(1));
    seed_vld = 1'b1; seed_data = s5;
    tick();
    seed_vld = 1'b0;
    reps = 0; rep_at = 0; n = 0;
    do begin
      tick();
      n++;
      if (rep_err) begin reps++; rep_at = n; end
    end while (!out_vld && n < 600);
    chk("rep_pulses", 256'(reps), 256'(1));
    chk("rep_pulse_time", 256'(rep_at), 256'(129));
    chk("rep_latency", 256'(n), 256'(258));
    e = adv(s5[SW-1 -: LW], taps, 256);
    chk("rep_word2", 256'(out_data), 256'(e[OW-1:0]));
    chk("rep_word_differs", 256'(out_data != w1), 256'(1));
    mode = 2'd0;
    tick();
    out_rdy = 1'b0; reseed_limit = 16'd0;

    // All-zero seed triggers lock-up recovery
    mode = 2'd1;
    tick();
    s = rnd_seed();
    s[SW-1 -: LW] = '0;
    seed_vld = 1'b1; seed_data = s;
    tick();
    seed_vld = 1'b0;
    chk("lock_pre", 256'(lockup), 256'(0));
    tick();
    chk("lock_pulse", 256'(lockup), 256'(1));
    tick();
    chk("lock_post", 256'(lockup), 256'(0));
    wait_vld(1000, n);
    chk("lock_latency", 256'(n), 256'(128));
    e = adv(def_seed, taps, 128);
    chk("lock_word", 256'(out_data), 256'(e[OW-1:0]));

    // Asynchronous reset mid-WARMUP
    out_rdy = 1'b1;
    tick();
    out_rdy = 1'b0;
    repeat (20) tick();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_data", 256'(out_data), 256'(def_seed[OW-1:0]));
    chk("arst_out_vld", 256'(out_vld), 256'(0));
    chk("arst_seed_req", 256'(seed_req), 256'(0));
    tick();
    rst = 1'b0;
    tick();
    chk("arst_restart_req", 256'(seed_req), 256'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lfsr_drng_gen.md
Name: lfsr_drng_gen

Overview:
Parametrised DRNG/post-processing generator, the next generation of the 129-bit LFSR post-processor in crypto_trng. An N-bit Fibonacci LFSR is seeded from the entropy buffer, then clocked freely (DRNG mode) or XOR-mixed with the digital noise bit (MIX mode). It emits OUT_W-bit words over a valid/ready handshake, reseeds after a programmable word count, and performs a repetition check on consecutive words. It sits between the entropy buffer and the RNG output FIFO.

Parameters:
LFSR_W, 129, LFSR length (>= OUT_W+1).
OUT_W, 128, output word width; word is lfsr[OUT_W-1:0].
SEED_W, 256, entropy buffer width; seed is seed_data[SEED_W-1 -: LFSR_W].
TAPS, bits {128,114,110,100,43,41} set, LFSR_W-bit feedback mask; feedback = XOR-reduce(lfsr & TAPS).
SEED_DEFAULT, 129'h1_A39A8864_5DF3BECE_074EC5D3_BAF39D18, reset/lock-up recovery value.
WARMUP, 8'd0, extra shifts after seeding before the first word is counted.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
mode  in  2  0=off, 1=DRNG, 2=MIX, 3=off
reseed_limit  in  16  words delivered per seed; 0 = never reseed
seed_req  out  1  level request for a new seed
seed_vld  in  1  seed_data valid; accepted when seed_req&seed_vld
seed_data  in  SEED_W  entropy buffer contents
noise_bit  in  1  digital noise bit (MIX mode)
noise_vld  in  1  noise_bit valid strobe
out_data  out  OUT_W  generated word
out_vld  out  1  word valid
out_rdy  in  1  consumer ready; transfer when out_vld&out_rdy
rep_err  out  1  1-cycle pulse: word equal to previous word was discarded
lockup  out  1  1-cycle pulse: all-zero LFSR detected and reloaded

Behaviour:
- Reset: lfsr=SEED_DEFAULT, state IDLE. seed_req, out_vld, rep_err and lockup are 0. out_data=SEED_DEFAULT[OUT_W-1:0]. Word and shift counters are 0; the previous-word register is 0 and its valid flag is 0.
- "step" means: DRNG step = every cycle. MIX step = only cycles with noise_vld, new bit = feedback^noise_bit. On a step, lfsr <= {lfsr[LFSR_W-2:0], newbit}.
- FSM:
  - IDLE: if mode in {1,2} go to SEED.
  - SEED: seed_req=1. On seed_req&seed_vld, load lfsr from the seed, clear the word counter, and go to WARMUP. seed_req drops in the cycle after acceptance.
  - WARMUP: WARMUP+OUT_W steps, then go to CHECK. With WARMUP=0, DRNG mode takes exactly OUT_W cycles.
  - CHECK (1 cycle): if prev valid and lfsr[OUT_W-1:0]==prev, pulse rep_err, clear the shift counter, and return to WARMUP with 0 warmup (OUT_W fresh steps). Otherwise latch out_data, set out_vld, go to OUT.
  - OUT: hold out_data/out_vld stable until out_rdy; the LFSR does not step. On transfer: prev<=out_data, prev valid=1, word_cnt++, out_vld=0. If reseed_limit!=0 and word_cnt+1==reseed_limit, go to SEED; else go to WARMUP with 0 warmup.
- Mode change (mode sampled every cycle, compared with a registered copy):
  - To off from any state: go to IDLE; out_vld=0, seed_req=0, counters and prev valid cleared. The lfsr value is retained.
  - Between DRNG and MIX: treated as a reseed; go to SEED and drop any pending word.
- Lock-up: if lfsr==0 in any state, reload SEED_DEFAULT that cycle and pulse lockup. This takes priority over step and seed load. The FSM state is unchanged.
- A seed whose slice is all zero is loaded, then caught by the lock-up rule the next cycle.
- word_cnt is 16 bits and saturates at 16'hFFFF when reseed_limit=0. The shift counter is 8 bits; WARMUP+OUT_W <= 255 is enforced by an elaboration-time check.
- Simultaneous out_rdy and mode->off: mode-off wins and the word is not counted. No output is combinational from inputs.

Decomposition:
- Shared package drng_pkg holds the FSM state enum (IDLE, SEED, WARMUP, CHECK, OUT), mode encodings, and default TAPS/SEED_DEFAULT constants for the 129-bit configuration.
- One natural sub-module, lfsr_core, holds the register, feedback XOR, load, zero-detect and step/mix inputs. The FSM, counters and repetition check live in the top.

Test Plan:
- Reset then mode=1, seed_data[255:127]=129'h1_0000...0001 accepted at cycle t -> seed_req high from IDLE+1 until t, first out_vld at t+1+128+1. out_data matches the golden LFSR model after 128 steps.
- mode=2 with noise_vld every 4th cycle, noise_bit=1 -> first word 128 steps later (about 512 cycles). Value equals the model with the noise XOR applied; no step on cycles without noise_vld.
- reseed_limit=3, out_rdy always 1 -> exactly 3 transfers, then seed_req=1. No out_vld until the new seed arrives; word_cnt restarts at 0.
- Force prev register equal to the next word -> rep_err single pulse, that word never appears on out_data, and the next valid word differs.
- Seed slice all-zero -> lockup pulse one cycle after load, lfsr=SEED_DEFAULT, generation continues.
- mode=1 with out_vld held and out_rdy=0, then mode=0 -> out_vld=0 and seed_req=0 the next cycle. Asserting rst mid-WARMUP gives reset values immediately (asynchronous).
